// File: rtl/sine_checksum_pkg.sv
// Shared types and defaults for the sine CORDIC checksum checker.
package sine_checksum_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int DEF_N_SAMPLES      = 10;
  localparam int DEF_DATA_W         = 32;
  localparam int DEF_SUM_W          = 32;
  localparam int DEF_TIMEOUT_CYCLES = 1024;

  function automatic int count_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/sine_checksum_checker_accumulator.sv
// Modular sum register and beat counter for one checksum run.
module checksum_accumulator
  import sine_checksum_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int SUM_W     = DEF_SUM_W,
  parameter int N_SAMPLES = DEF_N_SAMPLES,
  parameter int CNT_W     = count_width(DEF_N_SAMPLES)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              enable,
  input  logic [DATA_W-1:0] data,
  output logic [SUM_W-1:0]  sum,
  output logic [CNT_W-1:0]  count,
  output logic              last
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_SAMPLES - 1);

  logic [SUM_W-1:0] data_ext;

  generate
    if (DATA_W >= SUM_W) begin : g_trunc
      assign data_ext = data[SUM_W-1:0];
    end else begin : g_zext
      assign data_ext = {{(SUM_W-DATA_W){1'b0}}, data};
    end
  endgenerate

  // The beat that reaches N_SAMPLES is flagged combinationally so the FSM leaves RUN on that edge.
  assign last = enable && (count == LAST_CNT);

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      sum   <= '0;
      count <= '0;
    end else if (enable) begin
      sum   <= sum + data_ext;
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/sine_checksum_checker.sv
// Checksum sink for the sine CORDIC result stream; drives success/error flags.
// Optional watchdog enabled by defining CHECKSUM_TIMEOUT_EN (adds the timeout port).
module sine_checksum_checker
  import sine_checksum_pkg::*;
#(
  parameter int N_SAMPLES      = DEF_N_SAMPLES,
  parameter int DATA_W         = DEF_DATA_W,
  parameter int SUM_W          = DEF_SUM_W,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                              CLK100MHZ,
  input  logic                              reset_in_n,
  input  logic                              start,
  input  logic [SUM_W-1:0]                  expected_sum,
  input  logic                              m_axis_dout_tvalid,
  input  logic [63:0]                       m_axis_dout_tdata,
  output logic                              busy,
  output logic                              success,
  output logic                              error,
  output logic [SUM_W-1:0]                  sum,
  output logic [count_width(N_SAMPLES)-1:0] sample_count,
`ifdef CHECKSUM_TIMEOUT_EN
  output logic                              timeout,
`endif
  output logic [1:0]                        dbg_state
);

  // Stream handshake: no backpressure; a beat is consumed on every edge where
  // m_axis_dout_tvalid is high and the FSM is in RUN, and ignored otherwise.

  localparam int CNT_W = count_width(N_SAMPLES);

  state_t           state_q, state_d;
  logic             busy_q, success_q, success_d, error_q, error_d;
  logic [SUM_W-1:0] exp_q;
  logic             start_acc, acc_en, acc_last;

  checksum_accumulator #(
    .DATA_W    (DATA_W),
    .SUM_W     (SUM_W),
    .N_SAMPLES (N_SAMPLES),
    .CNT_W     (CNT_W)
  ) u_acc (
    .clk    (CLK100MHZ),
    .rst_n  (reset_in_n),
    .clear  (start_acc),
    .enable (acc_en),
    .data   (m_axis_dout_tdata[63 -: DATA_W]),
    .sum    (sum),
    .count  (sample_count),
    .last   (acc_last)
  );

`ifdef CHECKSUM_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0] wd_q;
  logic            timeout_q, timeout_d;

  // Counts consecutive beat-less RUN cycles.
  always_ff @(posedge CLK100MHZ) begin
    if (!reset_in_n || state_q != RUN || m_axis_dout_tvalid) wd_q <= '0;
    else                                                     wd_q <= wd_q + 1'b1;
  end

  always_ff @(posedge CLK100MHZ) begin
    if (!reset_in_n) timeout_q <= 1'b0;
    else             timeout_q <= timeout_d;
  end

  assign timeout = timeout_q;
`endif

  always_comb begin
    state_d   = state_q;
    success_d = success_q;
    error_d   = error_q;
    start_acc = 1'b0;
    acc_en    = 1'b0;
`ifdef CHECKSUM_TIMEOUT_EN
    timeout_d = timeout_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d   = RUN;
          start_acc = 1'b1;
          success_d = 1'b0;
          error_d   = 1'b0;
`ifdef CHECKSUM_TIMEOUT_EN
          timeout_d = 1'b0;
`endif
        end
      end
      RUN: begin
        acc_en = m_axis_dout_tvalid;
        if (acc_last) begin
          state_d = CHECK;
`ifdef CHECKSUM_TIMEOUT_EN
        end else if (!m_axis_dout_tvalid && wd_q == WD_LAST) begin
          state_d   = DONE;
          error_d   = 1'b1;
          timeout_d = 1'b1;
`endif
        end
      end
      CHECK: begin
        state_d = DONE;
        if (sum == exp_q) success_d = 1'b1;
        else              error_d   = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK100MHZ) begin
    if (!reset_in_n) begin
      state_q   <= IDLE;
      busy_q    <= 1'b0;
      success_q <= 1'b0;
      error_q   <= 1'b0;
      exp_q     <= '0;
    end else begin
      state_q   <= state_d;
      busy_q    <= (state_d == RUN) || (state_d == CHECK);
      success_q <= success_d;
      error_q   <= error_d;
      if (start_acc) exp_q <= expected_sum;
    end
  end

  assign busy      = busy_q;
  assign success   = success_q;
  assign error     = error_q;
  assign dbg_state = state_q;

  logic unused_ok;
  assign unused_ok = &{1'b0, m_axis_dout_tdata[63-DATA_W:0], TIMEOUT_CYCLES[0]};

endmodule

// File: tb/tb_sine_checksum_checker.sv
// Randomized self-checking bench for sine_checksum_checker (N_SAMPLES=4).
module tb_sine_checksum_checker;
  import sine_checksum_pkg::*;

  localparam int NS = 4;

  logic        CLK100MHZ = 1'b0;
  logic        reset_in_n;
  logic        start;
  logic [31:0] expected_sum;
  logic        m_axis_dout_tvalid;
  logic [63:0] m_axis_dout_tdata;
  logic        busy, success, error;
  logic [31:0] sum;
  logic [2:0]  sample_count;
  logic [1:0]  dbg_state;
`ifdef CHECKSUM_TIMEOUT_EN
  logic        timeout;
`endif

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] beat_q[$];
  logic [31:0] exp_q[$];

  sine_checksum_checker #(
    .N_SAMPLES      (NS),
    .DATA_W         (32),
    .SUM_W          (32),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .CLK100MHZ          (CLK100MHZ),
    .reset_in_n         (reset_in_n),
    .start              (start),
    .expected_sum       (expected_sum),
    .m_axis_dout_tvalid (m_axis_dout_tvalid),
    .m_axis_dout_tdata  (m_axis_dout_tdata),
    .busy               (busy),
    .success            (success),
    .error              (error),
    .sum                (sum),
    .sample_count       (sample_count),
`ifdef CHECKSUM_TIMEOUT_EN
    .timeout            (timeout),
`endif
    .dbg_state          (dbg_state)
  );

  // clock / reset
  always #5 CLK100MHZ = ~CLK100MHZ;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK100MHZ);
    #1;
  endtask

  // drivers
  task automatic send_beat(input logic [31:0] w);
    m_axis_dout_tvalid = 1'b1;
    m_axis_dout_tdata  = {w, 32'($urandom)};
    tick();
    m_axis_dout_tvalid = 1'b0;
    m_axis_dout_tdata  = {32'($urandom), 32'($urandom)};
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_success"}, 64'(success), 64'd0);
    check({tag, "_error"}, 64'(error), 64'd0);
    check({tag, "_sum"}, 64'(sum), 64'd0);
    check({tag, "_count"}, 64'(sample_count), 64'd0);
    check({tag, "_state"}, 64'(dbg_state), 64'(IDLE));
  endtask

  // One full run of beat_q; gaps may carry start pulses that must be ignored.
  task automatic run_case(input logic [31:0] exp_in, input int gap_max);
    longint      acc;
    logic [31:0] final_sum;
    logic        pass;
    acc = 0;
    exp_q.delete();
    foreach (beat_q[i]) begin
      acc = (acc + longint'(beat_q[i])) % (longint'(1) << 32);
      exp_q.push_back(acc[31:0]);
    end
    final_sum = acc[31:0];
    pass = (final_sum == exp_in);

    start = 1'b1;
    expected_sum = exp_in;
    m_axis_dout_tvalid = 1'b1;
    m_axis_dout_tdata = {32'($urandom), 32'($urandom)};
    tick();
    start = 1'b0;
    m_axis_dout_tvalid = 1'b0;
    expected_sum = 32'($urandom);
    check("start_busy", 64'(busy), 64'd1);
    check("start_count", 64'(sample_count), 64'd0);
    check("start_sum", 64'(sum), 64'd0);
    check("start_flags", {success, error}, 64'd0);

    foreach (beat_q[i]) begin
      repeat ($urandom_range(0, gap_max)) begin
        start = 1'($urandom_range(0, 1));
        tick();
        start = 1'b0;
      end
      send_beat(beat_q[i]);
      check("run_sum", 64'(sum), 64'(exp_q.pop_front()));
      check("run_count", 64'(sample_count), 64'(i + 1));
    end
    check("check_busy", 64'(busy), 64'd1);
    check("check_flags", {success, error}, 64'd0);
    tick();
    check("done_success", 64'(success), 64'(pass));
    check("done_error", 64'(error), 64'(!pass));
    check("done_busy", 64'(busy), 64'd0);
    check("done_sum", 64'(sum), 64'(final_sum));

    send_beat(32'($urandom));
    check("done_hold_sum", 64'(sum), 64'(final_sum));
    check("done_hold_count", 64'(sample_count), 64'(NS));
    check("done_hold_flags", {success, error}, {pass, !pass});
  endtask

  initial begin
    logic [31:0] w;
    longint      tot;

    reset_in_n = 1'b0;
    start = 1'b0;
    expected_sum = '0;
    m_axis_dout_tvalid = 1'b0;
    m_axis_dout_tdata = '0;
    tick();
    tick();
    reset_in_n = 1'b1;
    check_idle_zero("reset");
`ifdef CHECKSUM_TIMEOUT_EN
    check("reset_timeout", 64'(timeout), 64'd0);
`endif
    send_beat(32'd9);
    check("idle_ignore_sum", 64'(sum), 64'd0);

    beat_q = '{32'd1, 32'd2, 32'd3, 32'd4};
    run_case(32'd10, 0);
    run_case(32'd11, 0);
    beat_q = '{32'hFFFF_FFFF, 32'd2, 32'd0, 32'd0};
    run_case(32'd1, 0);

    // restart from DONE with no beats, then abort by reset
    start = 1'b1;
    tick();
    start = 1'b0;
    check("restart_success", 64'(success), 64'd0);
    check("restart_busy", 64'(busy), 64'd1);
    send_beat(32'd5);
    send_beat(32'd6);
    check("abort_sum", 64'(sum), 64'd11);
    check("abort_count", 64'(sample_count), 64'd2);
    reset_in_n = 1'b0;
    tick();
    reset_in_n = 1'b1;
    check_idle_zero("abort");
    send_beat(32'd7);
    check_idle_zero("after_abort");

    repeat (10) begin
      beat_q.delete();
      tot = 0;
      for (int i = 0; i < NS; i++) begin
        w = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF - 32'($urandom_range(0, 15)) : 32'($urandom);
        beat_q.push_back(w);
        tot += longint'(w);
      end
      if ($urandom_range(0, 1) == 1) run_case(32'(tot), 3);
      else                           run_case(32'(tot) ^ (32'd1 << $urandom_range(0, 31)), 3);
    end

`ifdef CHECKSUM_TIMEOUT_EN
    w = 32'($urandom);
    start = 1'b1;
    tick();
    start = 1'b0;
    send_beat(w);
    repeat (15) tick();
    check("wd_before_error", 64'(error), 64'd0);
    check("wd_before_busy", 64'(busy), 64'd1);
    tick();
    check("wd_error", 64'(error), 64'd1);
    check("wd_timeout", 64'(timeout), 64'd1);
    check("wd_success", 64'(success), 64'd0);
    check("wd_busy", 64'(busy), 64'd0);
    check("wd_sum", 64'(sum), 64'(w));
    check("wd_count", 64'(sample_count), 64'd1);
    check("wd_state", 64'(dbg_state), 64'(DONE));
    start = 1'b1;
    tick();
    start = 1'b0;
    check("wd_cleared", {timeout, error}, 64'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
